modexp_ctrl_unit: RTL and testbench
===================================

# modexp_ctrl_unit

Parametrised control unit for the RSA modular-exponentiation datapath. It sequences the Montgomery multiplier (MMM) through three phases: map into the Montgomery domain, one square-and-multiply round per exponent bit (right-to-left), and remap. It adds several features:

- start/busy/eoc handshake, so the unit can be restarted without a reset
- runtime exponent length
- synchronous abort
- configurable MMM cycle count

It sits between the register/SPI front end and the MMM, register and mux datapath.

## Interface
Parameters:
- WIDTH, 8: exponent and operand width in bits.
- MMM_CYCLES, WIDTH+2: clock-enabled cycles per MMM run; must be ≥ 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high; forces IDLE and clears all registers.
- ena  input  1  clock enable; when low, state, counters and exponent register hold.
- start  input  1  request; sampled only in IDLE or DONE while ena=1.
- abort  input  1  synchronous abort, effective when ena=1.
- expE  input  WIDTH  exponent; captured on start acceptance.
- exp_len  input  $clog2(WIDTH+1)  number of exponent bits to process; captured with expE; 0 or >WIDTH means WIDTH.
- rst_mmm  output  1  active-low MMM reset; 0 in IDLE and DONE, 1 otherwise.
- ld_a  output  1  load MMM operand A.
- ld_r  output  1  load MMM result into the result register.
- lock1  output  1  enable update of the result/accumulator register.
- lock2  output  1  enable update of the squaring register.
- sel1  output  2  operand mux: 00 = map, 01 = exponentiation, 10 = remap.
- sel2  output  1  second operand mux: 0 = map, 1 = otherwise.
- busy  output  1  high in every state except IDLE and DONE.
- eoc  output  1  end of computation; high in DONE only.
- round  output  $clog2(WIDTH+1)  current round index, for debug.

## Operation
- Registers:
  - state
  - step counter, width $clog2(MMM_CYCLES+1)
  - round counter, width $clog2(WIDTH+1)
  - exponent shift register reg_exp[WIDTH-1:0]
  - latched length L
- Outputs decode combinationally from state (Moore), except lock1, which uses reg_exp[0] in the MMM phase.
- States and outputs. Any output not listed is 0; sel1/sel2 default to 00/0.
  - IDLE: all outputs 0. start → PRE_MAP; reg_exp←expE, L←exp_len (normalised), counters←0.
  - PRE_MAP: rst_mmm, ld_a, lock1, lock2 = 1; sel1=00, sel2=0. → MAP.
  - MAP: rst_mmm, lock1, lock2 = 1; step increments. When step==MMM_CYCLES-1 → POST_MAP.
  - POST_MAP: as MAP, plus ld_r=1; step←0. → PRE_MMM.
  - PRE_MMM: rst_mmm, ld_a, lock2 = 1; lock1=reg_exp[0]; sel1=01, sel2=1. → MMM.
  - MMM: as PRE_MMM but ld_a=0; step increments. When step==MMM_CYCLES-1 → POST_MMM.
  - POST_MMM: as MMM, plus ld_r=1; step←0; reg_exp shifts right by 1; round increments.
    - round==L-1 → PRE_REMAP.
    - otherwise → PRE_MMM.
  - PRE_REMAP: rst_mmm, ld_a, lock1 = 1; lock2=0; sel1=10, sel2=1. → REMAP.
  - REMAP: as PRE_REMAP but ld_a=0; step increments. When step==MMM_CYCLES-1 → POST_REMAP.
  - POST_REMAP: as REMAP, plus ld_r=1; step←0. → DONE.
  - DONE: eoc=1, all other outputs 0. start → PRE_MAP with a fresh capture, as from IDLE.
- Illegal state encodings go to IDLE on the next enabled edge.
- abort=1 with ena=1 from any state:
  - next state IDLE; counters and reg_exp cleared.
  - abort has priority over start in the same cycle.
- start while busy is ignored; expE and exp_len changes while busy have no effect.
- Counters never wrap: they are compared with == and cleared in POST_* states.

## Timing
- Reset: state=IDLE and all outputs 0, asynchronously on rst, no clock needed.
- Start is accepted at edge k (state IDLE/DONE, start=1, ena=1). With N=MMM_CYCLES and L=normalised length:
  - PRE_MAP at k+1.
  - DONE, and eoc=1, at edge k+1+(L+2)(N+2).
- busy rises one cycle after acceptance; busy and eoc are never high together.
- eoc holds until start, abort or rst.
- ena=0 stretches every state 1:1; no outputs change except through reg_exp-dependent lock1, which also holds.
- rst mid-operation returns to IDLE immediately; a following start behaves as a fresh run.

## Test plan
- Reset: assert rst mid-MMM → all outputs 0 asynchronously; after release, state IDLE, busy=0, eoc=0.
- WIDTH=8, MMM_CYCLES=10, expE=0xA5, exp_len=0: start at edge k → eoc at k+121. lock1 per round (LSB first) = 1,0,1,0,0,1,0,1. ld_a pulses 10 times, ld_r pulses 10 times.
- expE=0x05, exp_len=3: eoc at k+61; 3 rounds; lock1 = 1,0,1; sel1 sequence 00→01→10.
- Pause: toggle ena low for 7 random cycles during MAP and during MMM → eoc is delayed by exactly 14 cycles; pulse counts unchanged.
- Abort in round 4 with start held high in the same cycle → IDLE next cycle, busy=0, no eoc. A new start then completes normally.
- Restart from DONE with expE=0xFF: eoc drops on acceptance, busy rises next cycle, eoc reasserts after 121 cycles. start pulses while busy have no effect.

Source files
------------

// File: rtl/modexp_ctrl_unit.sv
// Sequencer for the RSA modular-exponentiation datapath: drives the Montgomery
// multiplier through map, one square-and-multiply round per exponent bit (LSB first), and remap.
module modexp_ctrl_unit #(
  parameter int WIDTH      = 8,
  parameter int MMM_CYCLES = WIDTH + 2,
  localparam int RW        = $clog2(WIDTH + 1),
  localparam int SW        = $clog2(MMM_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] expE,
  input  logic [RW-1:0]    exp_len,
  output logic             rst_mmm,
  output logic             ld_a,
  output logic             ld_r,
  output logic             lock1,
  output logic             lock2,
  output logic [1:0]       sel1,
  output logic             sel2,
  output logic             busy,
  output logic             eoc,
  output logic [RW-1:0]    round
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PRE_MAP    = 4'd1,
    S_MAP        = 4'd2,
    S_POST_MAP   = 4'd3,
    S_PRE_MMM    = 4'd4,
    S_MMM        = 4'd5,
    S_POST_MMM   = 4'd6,
    S_PRE_REMAP  = 4'd7,
    S_REMAP      = 4'd8,
    S_POST_REMAP = 4'd9,
    S_DONE       = 4'd10
  } state_t;

  localparam logic [SW-1:0] STEP_LAST = SW'(MMM_CYCLES - 1);
  localparam logic [RW-1:0] LEN_MAX   = RW'(WIDTH);
  localparam logic [RW-1:0] RW_ONE    = RW'(1);
  localparam logic [SW-1:0] SW_ONE    = SW'(1);

  state_t           state;
  logic [SW-1:0]    step;
  logic [RW-1:0]    rnd;
  logic [WIDTH-1:0] reg_exp;
  logic [RW-1:0]    len_q;
  logic [RW-1:0]    len_norm;

  // A zero or oversized length means "process every exponent bit".
  assign len_norm = ((exp_len == '0) || (exp_len > LEN_MAX)) ? LEN_MAX : exp_len;
  assign round    = rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      step    <= '0;
      rnd     <= '0;
      reg_exp <= '0;
      len_q   <= '0;
    end else if (ena) begin
      if (abort) begin
        state   <= S_IDLE;
        step    <= '0;
        rnd     <= '0;
        reg_exp <= '0;
        len_q   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state   <= S_PRE_MAP;
              reg_exp <= expE;
              len_q   <= len_norm;
              step    <= '0;
              rnd     <= '0;
            end
          end
          S_PRE_MAP: state <= S_MAP;
          S_MAP: begin
            step <= step + SW_ONE;
            if (step == STEP_LAST) state <= S_POST_MAP;
          end
          S_POST_MAP: begin
            step  <= '0;
            state <= S_PRE_MMM;
          end
          S_PRE_MMM: state <= S_MMM;
          S_MMM: begin
            step <= step + SW_ONE;
            if (step == STEP_LAST) state <= S_POST_MMM;
          end
          S_POST_MMM: begin
            // Shifting here exposes the next exponent bit for the following round.
            step    <= '0;
            reg_exp <= reg_exp >> 1;
            rnd     <= rnd + RW_ONE;
            state   <= (rnd == len_q - RW_ONE) ? S_PRE_REMAP : S_PRE_MMM;
          end
          S_PRE_REMAP: state <= S_REMAP;
          S_REMAP: begin
            step <= step + SW_ONE;
            if (step == STEP_LAST) state <= S_POST_REMAP;
          end
          S_POST_REMAP: begin
            step  <= '0;
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
            step  <= '0;
            rnd   <= '0;
          end
        endcase
      end
    end
  end

  // Moore decode; lock1 follows the current exponent bit during the rounds.
  always_comb begin
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b0;
    lock2   = 1'b0;
    sel1    = 2'b00;
    sel2    = 1'b0;
    busy    = 1'b0;
    eoc     = 1'b0;
    case (state)
      S_PRE_MAP, S_MAP, S_POST_MAP: begin
        rst_mmm = 1'b1;
        busy    = 1'b1;
        lock1   = 1'b1;
        lock2   = 1'b1;
        ld_a    = (state == S_PRE_MAP);
        ld_r    = (state == S_POST_MAP);
      end
      S_PRE_MMM, S_MMM, S_POST_MMM: begin
        rst_mmm = 1'b1;
        busy    = 1'b1;
        lock1   = reg_exp[0];
        lock2   = 1'b1;
        sel1    = 2'b01;
        sel2    = 1'b1;
        ld_a    = (state == S_PRE_MMM);
        ld_r    = (state == S_POST_MMM);
      end
      S_PRE_REMAP, S_REMAP, S_POST_REMAP: begin
        rst_mmm = 1'b1;
        busy    = 1'b1;
        lock1   = 1'b1;
        sel1    = 2'b10;
        sel2    = 1'b1;
        ld_a    = (state == S_PRE_REMAP);
        ld_r    = (state == S_POST_REMAP);
      end
      S_DONE: eoc = 1'b1;
      default: ;
    endcase
  end

  a_busy_eoc_excl: assert property (@(posedge clk) disable iff (rst) !(busy && eoc));
  a_hold_when_off: assert property (@(posedge clk) disable iff (rst) !ena |=> $stable(state));
  a_step_bounded:  assert property (@(posedge clk) disable iff (rst) step <= SW'(MMM_CYCLES));

endmodule

// File: tb/tb_modexp_ctrl_unit.sv
// Directed bench for modexp_ctrl_unit with WIDTH=8, MMM_CYCLES=10 (one phase = 12 cycles).
module tb_modexp_ctrl_unit;
  localparam int WIDTH = 8;
  localparam int NCYC  = 10;
  localparam int RW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, ena, start, abort;
  logic [WIDTH-1:0] expE;
  logic [RW-1:0]    exp_len;
  logic             rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
  logic [1:0]       sel1;
  logic [RW-1:0]    round;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modexp_ctrl_unit #(.WIDTH(WIDTH), .MMM_CYCLES(NCYC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
    .expE(expE), .exp_len(exp_len), .rst_mmm(rst_mmm), .ld_a(ld_a),
    .ld_r(ld_r), .lock1(lock1), .lock2(lock2), .sel1(sel1), .sel2(sel2),
    .busy(busy), .eoc(eoc), .round(round)
  );

  // Start handshake; returns at the negedge right after the accepting edge.
  task automatic kick(input logic [WIDTH-1:0] e, input logic [RW-1:0] len);
    @(negedge clk);
    ena = 1'b1; abort = 1'b0; start = 1'b1; expE = e; exp_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one operation and records what the outputs did until eoc (or a 400-cycle budget).
  task automatic run_op(input logic [WIDTH-1:0] e, input logic [RW-1:0] len,
                        input bit do_pause, input bit do_bstart,
                        output int lat, output int n_lda, output int n_ldr,
                        output logic [7:0] l1, output int nrnd,
                        output logic [5:0] selseq, output int nsel, output int sig_err,
                        output logic first_busy, output logic first_eoc);
    int hold;
    bit map_p, mmm_p;
    logic [1:0] last_sel;
    kick(e, len);
    lat = 1; n_lda = 0; n_ldr = 0; l1 = '0; nrnd = 0; selseq = '0; nsel = 0; sig_err = 0;
    hold = 0; map_p = 0; mmm_p = 0; last_sel = 2'b11;
    first_busy = busy; first_eoc = eoc;
    while (eoc !== 1'b1 && lat < 400) begin
      if (ld_a) n_lda++;
      if (ld_r) n_ldr++;
      if (ld_r && sel1 == 2'b01) begin
        if (nrnd < 8) l1[nrnd] = lock1;
        nrnd++;
      end
      if (sel1 != last_sel) begin
        selseq = {selseq[3:0], sel1};
        nsel++;
        last_sel = sel1;
      end
      if (busy !== 1'b1 || rst_mmm !== 1'b1 || sel2 !== (sel1 != 2'b00) ||
          lock2 !== (sel1 != 2'b10)) sig_err++;
      if (do_pause && hold == 0) begin
        if (!map_p && sel1 == 2'b00 && !ld_a && !ld_r) begin map_p = 1; hold = 7; end
        else if (map_p && !mmm_p && sel1 == 2'b01 && !ld_a && !ld_r) begin mmm_p = 1; hold = 7; end
      end
      if (hold > 0) begin ena = 1'b0; hold--; end
      else ena = 1'b1;
      start = do_bstart && (lat == 5 || lat == 30 || lat == 70);
      if (start) begin expE = '0; exp_len = 4'd1; end
      @(negedge clk);
      lat++;
    end
    ena = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b0; start = 1'b0; abort = 1'b0; expE = '0; exp_len = '0;
    #1;
    total++;
    if ({rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, round} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want all zero",
                      {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, round});
    end
    @(negedge clk); rst = 1'b0; ena = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || eoc !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b eoc=%b want 0 0", busy, eoc);
    end
  endtask

  task automatic test_mid_reset;
    kick(8'hA5, '0);
    repeat (19) @(negedge clk);
    total++;
    if (busy !== 1'b1 || sel1 !== 2'b01) begin
      bad++; $display("FAIL mid_reset_in_mmm: busy=%b sel1=%b want 1 01", busy, sel1);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, round} !== '0) begin
      bad++; $display("FAIL mid_reset_async: got %b want all zero",
                      {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, round});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || eoc !== 1'b0 || round !== '0) begin
      bad++; $display("FAIL mid_reset_idle: busy=%b eoc=%b round=%0d want 0 0 0", busy, eoc, round);
    end
  endtask

  task automatic test_len3;
    int lat, na, nr, nrnd, nsel, serr;
    logic [7:0] l1; logic [5:0] ss; logic fb, fe;
    run_op(8'h05, 4'd3, 0, 0, lat, na, nr, l1, nrnd, ss, nsel, serr, fb, fe);
    total++;
    if (lat !== 61) begin bad++; $display("FAIL len3_latency: got %0d want 61", lat); end
    total++;
    if (nrnd !== 3 || l1 !== 8'h05) begin
      bad++; $display("FAIL len3_lock1: rounds=%0d bits=%b want 3 00000101", nrnd, l1);
    end
    total++;
    if (nsel !== 3 || ss !== 6'b00_01_10) begin
      bad++; $display("FAIL len3_sel1_seq: n=%0d seq=%b want 3 000110", nsel, ss);
    end
    total++;
    if (na !== 5 || nr !== 5) begin
      bad++; $display("FAIL len3_pulses: ld_a=%0d ld_r=%0d want 5 5", na, nr);
    end
    total++;
    if (serr !== 0 || fb !== 1'b1 || fe !== 1'b0) begin
      bad++; $display("FAIL len3_decode: errs=%0d busy0=%b eoc0=%b want 0 1 0", serr, fb, fe);
    end
    total++;
    if (eoc !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL len3_done: eoc=%b busy=%b want 1 0", eoc, busy);
    end
  endtask

  task automatic test_full_a5;
    int lat, na, nr, nrnd, nsel, serr;
    logic [7:0] l1; logic [5:0] ss; logic fb, fe;
    run_op(8'hA5, 4'd0, 0, 0, lat, na, nr, l1, nrnd, ss, nsel, serr, fb, fe);
    total++;
    if (lat !== 121) begin bad++; $display("FAIL a5_latency: got %0d want 121", lat); end
    total++;
    if (nrnd !== 8 || l1 !== 8'hA5) begin
      bad++; $display("FAIL a5_lock1: rounds=%0d bits=%h want 8 a5", nrnd, l1);
    end
    total++;
    if (na !== 10 || nr !== 10) begin
      bad++; $display("FAIL a5_pulses: ld_a=%0d ld_r=%0d want 10 10", na, nr);
    end
    total++;
    if (serr !== 0 || round !== 4'd8) begin
      bad++; $display("FAIL a5_decode: errs=%0d round=%0d want 0 8", serr, round);
    end
  endtask

  task automatic test_pause;
    int lat, na, nr, nrnd, nsel, serr;
    logic [7:0] l1; logic [5:0] ss; logic fb, fe;
    run_op(8'hA5, 4'd0, 1, 0, lat, na, nr, l1, nrnd, ss, nsel, serr, fb, fe);
    total++;
    if (lat !== 135) begin bad++; $display("FAIL pause_latency: got %0d want 135", lat); end
    total++;
    if (na !== 10 || nr !== 10 || l1 !== 8'hA5 || serr !== 0) begin
      bad++; $display("FAIL pause_pulses: ld_a=%0d ld_r=%0d bits=%h errs=%0d want 10 10 a5 0",
                      na, nr, l1, serr);
    end
  endtask

  task automatic test_abort;
    int lat, na, nr, nrnd, nsel, serr, seen;
    logic [7:0] l1; logic [5:0] ss; logic fb, fe;
    kick(8'hA5, '0);
    repeat (54) @(negedge clk);
    total++;
    if (round !== 4'd3 || sel1 !== 2'b01) begin
      bad++; $display("FAIL abort_round4: round=%0d sel1=%b want 3 01", round, sel1);
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || eoc !== 1'b0 || rst_mmm !== 1'b0 || round !== '0) begin
      bad++; $display("FAIL abort_idle: busy=%b eoc=%b rst_mmm=%b round=%0d want 0 0 0 0",
                      busy, eoc, rst_mmm, round);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || eoc) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_quiet: active cycles=%0d want 0", seen); end
    run_op(8'hA5, 4'd0, 0, 0, lat, na, nr, l1, nrnd, ss, nsel, serr, fb, fe);
    total++;
    if (lat !== 121 || l1 !== 8'hA5 || serr !== 0) begin
      bad++; $display("FAIL abort_rerun: lat=%0d bits=%h errs=%0d want 121 a5 0", lat, l1, serr);
    end
  endtask

  task automatic test_restart;
    int lat, na, nr, nrnd, nsel, serr;
    logic [7:0] l1; logic [5:0] ss; logic fb, fe;
    total++;
    if (eoc !== 1'b1) begin bad++; $display("FAIL restart_prev_done: eoc=%b want 1", eoc); end
    run_op(8'hFF, 4'd0, 0, 1, lat, na, nr, l1, nrnd, ss, nsel, serr, fb, fe);
    total++;
    if (fe !== 1'b0 || fb !== 1'b1) begin
      bad++; $display("FAIL restart_accept: eoc=%b busy=%b want 0 1", fe, fb);
    end
    total++;
    if (lat !== 121 || l1 !== 8'hFF || nrnd !== 8 || na !== 10 || serr !== 0) begin
      bad++; $display("FAIL restart_run: lat=%0d bits=%h rounds=%0d ld_a=%0d errs=%0d want 121 ff 8 10 0",
                      lat, l1, nrnd, na, serr);
    end
    repeat (5) @(negedge clk);
    total++;
    if (eoc !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL restart_eoc_hold: eoc=%b busy=%b want 1 0", eoc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_len3();
    test_full_a5();
    test_pause();
    test_abort();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
